// File: rtl/button_led_arbiter_if.sv
// Pushbutton/LED bundle for button_led_arbiter. The drop_count signal exists only
// when BUTTON_LED_ARBITER_DROP_CNT_EN is defined.
interface button_led_arbiter_if #(
   parameter int NUM_BTN = 4
);
   localparam int GID_W = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1;

   // Request/grant contract: a debounced press of pushbutton[i] raises pending[i]
   // (one deep); the grant is visible as busy=1 with grant_id=i for the whole
   // blink sequence, and pending[i] drops the cycle the grant is taken.
   logic [NUM_BTN-1:0] pushbutton;
   logic               led;
   logic               busy;
   logic [GID_W-1:0]   grant_id;
   logic [NUM_BTN-1:0] pending;
   logic [1:0]         dbg_state;
   logic [GID_W-1:0]   dbg_rr_ptr;
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
   logic [7:0]         drop_count;
`endif

   modport slave (
      input  pushbutton,
      output led, busy, grant_id, pending, dbg_state, dbg_rr_ptr
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
      , output drop_count
`endif
   );

   modport master (
      output pushbutton,
      input  led, busy, grant_id, pending, dbg_state, dbg_rr_ptr
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
      , input drop_count
`endif
   );
endinterface

// File: rtl/button_led_arbiter.sv
// Round-robin sharing of one LED between debounced pushbuttons; the granted button
// blinks (index+1) pulses then a gap. BUTTON_LED_ARBITER_DROP_CNT_EN adds drop_count.
module button_led_arbiter #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ON_CYCLES       = 5000000,
   parameter int OFF_CYCLES      = 5000000,
   parameter int GAP_CYCLES      = 20000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   button_led_arbiter_if.slave  bus
);

   localparam int GID_W  = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1;
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int MAX_OO = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAX_T  = (MAX_OO > GAP_CYCLES) ? MAX_OO : GAP_CYCLES;
   localparam int TMR_W  = $clog2(MAX_T + 1);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
   localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
   localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NUM_BTN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic [NUM_BTN-1:0] deb_q, deb_d;
   logic [NUM_BTN-1:0] deb_prev_q, deb_prev_d;
   logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
   logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] pending_q, pending_d;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] clr;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [GID_W-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [GID_W-1:0]   grant_id_q, grant_id_d;
   logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               led_q, led_d;
   logic               busy_q, busy_d;

   logic               sel_found;
   logic [GID_W-1:0]   sel_idx;

   // Synchroniser and per-button debounce; the level flips only after the synced
   // input has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      sync1_d    = bus.pushbutton;
      sync2_d    = sync1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign rise = deb_q & ~deb_prev_q;

   // First pending request at or above rr_ptr, wrapping around.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_BTN; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_BTN) begin
            idx = idx - NUM_BTN;
         end
         if (!sel_found && pending_q[idx]) begin
            sel_found = 1'b1;
            sel_idx   = GID_W'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      pulse_cnt_d = pulse_cnt_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      led_d       = led_q;
      busy_d      = busy_q;
      clr         = '0;
      case (state_q)
         S_IDLE: begin
            led_d      = 1'b0;
            busy_d     = 1'b0;
            grant_id_d = '0;
            if (sel_found) begin
               state_d      = S_ON;
               led_d        = 1'b1;
               busy_d       = 1'b1;
               grant_id_d   = sel_idx;
               pulse_cnt_d  = '0;
               timer_d      = '0;
               clr[sel_idx] = 1'b1;
            end
         end
         S_ON: begin
            if (timer_q == ON_LAST) begin
               state_d = S_OFF;
               led_d   = 1'b0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_OFF: begin
            if (timer_q == OFF_LAST) begin
               timer_d = '0;
               if (pulse_cnt_q == grant_id_q) begin
                  state_d = S_GAP;
               end else begin
                  state_d     = S_ON;
                  led_d       = 1'b1;
                  pulse_cnt_d = pulse_cnt_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == GAP_LAST) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               grant_id_d = '0;
               timer_d    = '0;
               rr_ptr_d   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            led_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // A capture in the same cycle as the grant clear wins.
   assign pending_d = (pending_q & ~clr) | rise;

`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
   logic [NUM_BTN-1:0] drop;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic [8:0]         drop_sum;

   assign drop = rise & pending_q & ~clr;

   always_comb begin
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < NUM_BTN; i++) begin
         drop_sum = drop_sum + 9'(drop[i]);
      end
      drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
   end

   assign bus.drop_count = drop_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         deb_prev_q  <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_q[i] <= '0;
         end
         pending_q   <= '0;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         pulse_cnt_q <= '0;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         led_q       <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
         drop_cnt_q  <= '0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_prev_q  <= deb_prev_d;
         db_cnt_q    <= db_cnt_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         pulse_cnt_q <= pulse_cnt_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
         drop_cnt_q  <= drop_cnt_d;
`endif
      end
   end

   assign bus.led        = led_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant_id_q;
   assign bus.pending    = pending_q;
   assign bus.dbg_state  = state_q;
   assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_button_led_arbiter.sv
// Directed bench for button_led_arbiter with short timing parameters; drop_count
// checks are built only when BUTTON_LED_ARBITER_DROP_CNT_EN is defined.
module tb_button_led_arbiter;

   localparam int NB  = 4;
   localparam int DEB = 4;
   localparam int ONC = 3;
   localparam int OFC = 2;
   localparam int GPC = 5;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   button_led_arbiter_if #(.NUM_BTN(NB)) bus ();

   button_led_arbiter #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB),
      .ON_CYCLES(ONC), .OFF_CYCLES(OFC), .GAP_CYCLES(GPC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      bus.pushbutton = '0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic press(input int b, input int hold, input int low);
      bus.pushbutton[b] = 1'b1;
      tick(hold);
      bus.pushbutton[b] = 1'b0;
      tick(low);
   endtask

   // Follows one grant from busy rising to busy falling, counting LED pulses.
   task automatic run_grant(output int id, output int pulses, output bit ok);
      int   t;
      logic prev;
      ok = 1'b1;
      t  = 0;
      while (!bus.busy && t < 60) begin
         tick(1);
         t++;
      end
      if (!bus.busy) begin
         ok     = 1'b0;
         id     = -1;
         pulses = 0;
         return;
      end
      id     = int'(bus.grant_id);
      pulses = bus.led ? 1 : 0;
      prev   = bus.led;
      t      = 0;
      while (bus.busy && t < 200) begin
         tick(1);
         t++;
         if (bus.led && !prev) pulses++;
         prev = bus.led;
      end
      ok = !bus.busy;
   endtask

   initial begin
      logic [19:0] got_pat;
      logic [19:0] exp_pat;
      int          cnt;
      int          id;
      int          pulses;
      bit          ok;

      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      bus.pushbutton = '0;
      #3;
      chk("rst_led", 32'(bus.led), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      chk("rst_grant", 32'(bus.grant_id), 32'd0);
      chk("rst_state", 32'(bus.dbg_state), 32'd0);
      do_reset();

      // Clean press on button 2: pending 7 cycles after the raw edge, LED one later.
      bus.pushbutton[2] = 1'b1;
      tick(6);
      chk("t1_pending_early", 32'(bus.pending), 32'd0);
      tick(1);
      chk("t1_pending", 32'(bus.pending), 32'b0100);
      chk("t1_led_before", 32'(bus.led), 32'd0);
      bus.pushbutton[2] = 1'b0;
      tick(1);
      chk("t1_led", 32'(bus.led), 32'd1);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_grant", 32'(bus.grant_id), 32'd2);
      chk("t1_pending_clr", 32'(bus.pending), 32'd0);
      for (int n = 0; n < 20; n++) begin
         exp_pat[n] = (n < 3 * (ONC + OFC)) && ((n % (ONC + OFC)) < ONC);
      end
      got_pat    = '0;
      got_pat[0] = bus.led;
      cnt        = 0;
      while (bus.busy && cnt < 40) begin
         tick(1);
         cnt++;
         if (cnt < 20) got_pat[cnt] = bus.led;
      end
      chk("t1_busy_len", 32'(cnt), 32'd20);
      chk("t1_led_pattern", 32'(got_pat), 32'(exp_pat));
      chk("t1_grant_idle", 32'(bus.grant_id), 32'd0);
      chk("t1_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd3);

      // Two-cycle glitch on button 0 must be filtered.
      bus.pushbutton[0] = 1'b1;
      tick(2);
      bus.pushbutton[0] = 1'b0;
      tick(20);
      chk("t2_pending", 32'(bus.pending), 32'd0);
      chk("t2_led", 32'(bus.led), 32'd0);
      chk("t2_busy", 32'(bus.busy), 32'd0);

      // All four at once after reset: served 0,1,2,3 with 1..4 pulses.
      do_reset();
      bus.pushbutton = 4'hF;
      tick(7);
      chk("t3_pending", 32'(bus.pending), 32'hF);
      bus.pushbutton = '0;
      for (int g = 0; g < NB; g++) begin
         run_grant(id, pulses, ok);
         chk($sformatf("t3_ok%0d", g), 32'(ok), 32'd1);
         chk($sformatf("t3_id%0d", g), 32'(id), 32'(g));
         chk($sformatf("t3_pulses%0d", g), 32'(pulses), 32'(g + 1));
      end
      chk("t3_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
      chk("t3_pending_end", 32'(bus.pending), 32'd0);

      // Button 1 re-pressed twice during its own sequence: one re-grant, one drop.
      press(1, 4, 4);
      chk("t4_busy", 32'(bus.busy), 32'd1);
      chk("t4_grant", 32'(bus.grant_id), 32'd1);
      press(1, 4, 4);
      press(1, 4, 4);
      chk("t4_regrant_busy", 32'(bus.busy), 32'd1);
      chk("t4_regrant_state", 32'(bus.dbg_state), 32'd1);
      chk("t4_pending_after", 32'(bus.pending), 32'd0);
      run_grant(id, pulses, ok);
      chk("t4_ok", 32'(ok), 32'd1);
      chk("t4_id", 32'(id), 32'd1);
      chk("t4_pulses", 32'(pulses), 32'd2);
      tick(30);
      chk("t4_no_third", 32'(bus.busy), 32'd0);
      chk("t4_pending_end", 32'(bus.pending), 32'd0);
      chk("t4_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd2);
`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
      chk("t4_drop_count", 32'(bus.drop_count), 32'd1);
`endif

      // Reset mid-ON of button 3 with pending=1010 clears everything at once.
      do_reset();
      press(3, 4, 4);
      chk("t5_grant", 32'(bus.grant_id), 32'd3);
      bus.pushbutton = 4'b1010;
      tick(7);
      chk("t5_pending", 32'(bus.pending), 32'b1010);
      chk("t5_led_on", 32'(bus.led), 32'd1);
      rst_n          = 1'b0;
      bus.pushbutton = '0;
      #2;
      chk("t5_async_led", 32'(bus.led), 32'd0);
      chk("t5_async_busy", 32'(bus.busy), 32'd0);
      chk("t5_async_pending", 32'(bus.pending), 32'd0);
      chk("t5_async_grant", 32'(bus.grant_id), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(30);
      chk("t5_idle_busy", 32'(bus.busy), 32'd0);
      chk("t5_idle_led", 32'(bus.led), 32'd0);
      chk("t5_idle_pending", 32'(bus.pending), 32'd0);

`ifdef BUTTON_LED_ARBITER_DROP_CNT_EN
      // Hammer all buttons far faster than they can be served.
      chk("t6_drop_reset", 32'(bus.drop_count), 32'd0);
      for (int r = 0; r < 100; r++) begin
         bus.pushbutton = 4'hF;
         tick(4);
         bus.pushbutton = '0;
         tick(4);
      end
      cnt = 0;
      while ((bus.busy || bus.pending != '0) && cnt < 400) begin
         tick(1);
         cnt++;
      end
      chk("t6_drained", 32'(bus.busy || bus.pending != '0), 32'd0);
      chk("t6_drop_sat", 32'(bus.drop_count), 32'd255);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
